// File: rtl/sifh_zoom_pkg.sv
// Shared types and helpers for the multi-stage histogram zoom controller.
//   state_e    : controller FSM states
//   span_lg2   : log2 of the window span at a given stage
//   bw_lg2     : log2 of the histogram bin width at a given stage (= bin_shift)
//   params_ok  : legality of the parameter set, checked at elaboration
package sifh_zoom_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_OFFER     = 3'd1,
    ST_WAIT_PEAK = 3'd2,
    ST_CALC0     = 3'd3,
    ST_CALC1     = 3'd4
  } state_e;

  function automatic int span_lg2(input int s, input int np, input int zs);
    return np - s * zs;
  endfunction

  function automatic int bw_lg2(input int s, input int np, input int nb, input int zs);
    return np - s * zs - nb;
  endfunction

  function automatic bit params_ok(input int nb, input int np, input int zs,
                                   input int nstage, input int max_retry);
    return (zs >= 1) && (zs <= nb - 1) && (nstage >= 1) && (max_retry >= 1) &&
           (np - (nstage - 1) * zs - nb >= 0);
  endfunction

endpackage

// File: rtl/zoom_clamp.sv
// Combinational zoom arithmetic for one stage.
//   lo_i       : current window lower bound (NP+1 bits, always < 2^NP)
//   s_i        : current stage index
//   peak_bin_i : peak bin reported for the current window
//   c_o        : bin centre, lo + bin*bw + bw/2
//   lo_nxt_o   : next-stage lower bound, centred on c and kept inside the current window
module zoom_clamp
  import sifh_zoom_pkg::*;
#(
  parameter int NB = 8,
  parameter int NP = 16,
  parameter int ZS = 4,
  parameter int SW = 2
) (
  input  logic [NP:0]   lo_i,
  input  logic [SW-1:0] s_i,
  input  logic [NB-1:0] peak_bin_i,
  output logic [NP-1:0] c_o,
  output logic [NP:0]   lo_nxt_o
);

  localparam logic [NP:0] ONE = (NP+1)'(1);

  int          bw_lg, span_lg, nxt_lg;
  logic [NP:0] c, half, lo_max, base;

  always_comb begin
    bw_lg   = bw_lg2(int'(s_i), NP, NB, ZS);
    span_lg = span_lg2(int'(s_i), NP, ZS);
    nxt_lg  = span_lg - ZS;
    c = lo_i + ((NP+1)'(peak_bin_i) << bw_lg);
    // single-unit bins have no half-bin offset
    if (bw_lg > 0) c = c + (ONE << (bw_lg - 1));
    // on the last stage there is no next span; lo_nxt is never consumed there
    half   = '0;
    lo_max = lo_i;
    if (nxt_lg > 0) begin
      half   = ONE << (nxt_lg - 1);
      lo_max = lo_i + (ONE << span_lg) - (ONE << nxt_lg);
    end
    // floor at zero before clamping into [lo, lo+span-span_next]
    base = (c >= half) ? c - half : '0;
    if (base < lo_i)        lo_nxt_o = lo_i;
    else if (base > lo_max) lo_nxt_o = lo_max;
    else                    lo_nxt_o = base;
  end

  assign c_o = c[NP-1:0];

endmodule

// File: rtl/zoom_window_ctrl.sv
// Multi-stage histogram zoom controller. Offers a time window to the histogram
// builder, takes back the peak bin, narrows the window around it, and after
// NSTAGE passes reports the time of flight. No-peak results are retried.
//   clk, rst_n                : clock, async active-low reset
//   start                     : begin/restart a measurement (overrides everything)
//   win_valid/win_ready       : window offer handshake (th_lo, th_hi, bin_shift, stage)
//   peak_valid/peak_ready     : peak result handshake (peak_bin, peak_miss)
//   result_valid, result_tof  : final TOF pulse and held value
//   err                       : retry-exhaustion pulse
//   busy                      : controller not idle
module zoom_window_ctrl
  import sifh_zoom_pkg::*;
#(
  parameter int NB        = 8,
  parameter int NP        = 16,
  parameter int ZS        = 4,
  parameter int NSTAGE    = 3,
  parameter int MAX_RETRY = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [NP-1:0]              th_lo,
  output logic [NP-1:0]              th_hi,
  output logic [$clog2(NP+1)-1:0]    bin_shift,
  output logic [$clog2(NSTAGE+1)-1:0] stage,
  input  logic                       peak_valid,
  output logic                       peak_ready,
  input  logic [NB-1:0]              peak_bin,
  input  logic                       peak_miss,
  output logic                       result_valid,
  output logic [NP-1:0]              result_tof,
  output logic                       err,
  output logic                       busy
);

  localparam int SW  = $clog2(NSTAGE + 1);
  localparam int BSW = $clog2(NP + 1);
  localparam int RW  = $clog2(MAX_RETRY + 1);
  localparam logic [NP:0] ONE = (NP+1)'(1);

  if (!params_ok(NB, NP, ZS, NSTAGE, MAX_RETRY)) begin : g_bad_params
    $error("zoom_window_ctrl: illegal parameter set");
  end

  state_e        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [NP:0]   lo_q, lo_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [NB-1:0] pbin_q, pbin_d;
  logic [NP-1:0] c_q, c_d, tof_q, tof_d;
  logic          rv_q, rv_d, err_q, err_d;

  logic [NP-1:0] c_w;
  logic [NP:0]   lo_nxt_w, win_hi;
  logic          unused_hi;
  int            span_lg;

  zoom_clamp #(.NB(NB), .NP(NP), .ZS(ZS), .SW(SW)) u_clamp (
    .lo_i       (lo_q),
    .s_i        (stage_q),
    .peak_bin_i (pbin_q),
    .c_o        (c_w),
    .lo_nxt_o   (lo_nxt_w)
  );

  assign busy       = (state_q != ST_IDLE);
  assign win_valid  = (state_q == ST_OFFER);
  assign peak_ready = (state_q == ST_WAIT_PEAK) & ~start;

  always_comb begin
    span_lg = span_lg2(int'(stage_q), NP, ZS);
    win_hi  = lo_q + (ONE << span_lg) - ONE;
  end
  assign unused_hi = win_hi[NP];  // window never reaches 2^NP

  // window outputs read zero while idle so reset shows all-zero outputs
  assign th_lo     = busy ? lo_q[NP-1:0]   : '0;
  assign th_hi     = busy ? win_hi[NP-1:0] : '0;
  assign bin_shift = busy ? BSW'(bw_lg2(int'(stage_q), NP, NB, ZS)) : '0;
  assign stage        = stage_q;
  assign result_valid = rv_q;
  assign result_tof   = tof_q;
  assign err          = err_q;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    lo_d    = lo_q;
    retry_d = retry_q;
    pbin_d  = pbin_q;
    c_d     = c_q;
    tof_d   = tof_q;
    rv_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_OFFER: if (win_ready) state_d = ST_WAIT_PEAK;
      ST_WAIT_PEAK: begin
        if (peak_valid && peak_ready) begin
          if (peak_miss) begin
            if (retry_q == RW'(MAX_RETRY - 1)) begin
              err_d   = 1'b1;
              retry_d = '0;
              state_d = ST_IDLE;
            end else begin
              retry_d = retry_q + RW'(1);
              state_d = ST_OFFER;
            end
          end else begin
            retry_d = '0;
            pbin_d  = peak_bin;
            state_d = ST_CALC0;
          end
        end
      end
      ST_CALC0: begin
        c_d     = c_w;
        state_d = ST_CALC1;
      end
      ST_CALC1: begin
        if (int'(stage_q) == NSTAGE - 1) begin
          tof_d   = c_q;
          rv_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          lo_d    = lo_nxt_w;
          stage_d = stage_q + SW'(1);
          state_d = ST_OFFER;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d = ST_OFFER;
      stage_d = '0;
      lo_d    = '0;
      retry_d = '0;
      rv_d    = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      lo_q    <= '0;
      retry_q <= '0;
      pbin_q  <= '0;
      c_q     <= '0;
      tof_q   <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      lo_q    <= lo_d;
      retry_q <= retry_d;
      pbin_q  <= pbin_d;
      c_q     <= c_d;
      tof_q   <= tof_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
    end
  end

endmodule
